// File: rtl/axi_line_master_pkg.sv
// Shared AXI encodings and the state types of the line master's read and write engines.
package axi_line_master_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} line_rd_state_t;
    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE} line_wr_state_t;

endpackage

// File: rtl/axi_line_master_if.sv
// AXI3/4 channel bundle between the line master and one crossbar slave port.
interface axi_line_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]          arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid, arready;

    logic [3:0]          rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast, rvalid, rready;

    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid, awready;

    logic [3:0]          wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast, wvalid, wready;

    logic [3:0]          bid;
    logic [1:0]          bresp;
    logic                bvalid, bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_burst_counter.sv
// Beat counter for one burst engine: cleared on accept, stepped per handshake,
// flags the beat whose index equals the burst length.
module axi_burst_counter #(
    parameter int CNT_W = 3,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] last_idx,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) cnt <= '0;
        else if (inc)       cnt <= cnt + 1'b1;
    end

    assign idx  = cnt[IDX_W-1:0];
    assign last = (cnt == last_idx);
endmodule

// File: rtl/axi_line_master.sv
// Single-ID AXI burst engine: independent line-refill read and line-writeback write,
// each optionally a single uncached beat with caller-supplied size/strobe.
module axi_line_master
    import axi_line_master_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rd_req,
    input  logic                         rd_uncached,
    input  logic [2:0]                   rd_size,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         rd_rdy,
    output logic                         rd_valid,
    output logic                         rd_err,
    output logic [LINE_WORDS*DATA_W-1:0] rd_data,
    input  logic                         wr_req,
    input  logic                         wr_uncached,
    input  logic [2:0]                   wr_size,
    input  logic [DATA_W/8-1:0]          wr_strb,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [LINE_WORDS*DATA_W-1:0] wr_data,
    output logic                         wr_rdy,
    output logic                         wr_done,
    output logic                         wr_err,
    axi_line_master_if.master            axi
);
    localparam int         CNT_W     = $clog2(LINE_WORDS) + 1;
    localparam int         IDX_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int         STRB_W    = DATA_W / 8;
    localparam logic [7:0] LINE_LEN  = 8'(LINE_WORDS - 1);
    localparam logic [2:0] FULL_SIZE = 3'($clog2(STRB_W));

    // ---------------- read engine ----------------
    line_rd_state_t                     rd_state, rd_next;
    logic [ADDR_W-1:0]                  rd_addr_q;
    logic [2:0]                         rd_size_q;
    logic                               rd_unc_q, rd_err_q;
    logic [LINE_WORDS-1:0][DATA_W-1:0]  rd_line;
    logic [7:0]                         rd_len;
    logic [IDX_W-1:0]                   rd_idx;
    logic                               rd_last, rd_accept, rd_beat;

    assign rd_len    = rd_unc_q ? 8'd0 : LINE_LEN;
    assign rd_accept = rd_req && (rd_state == R_IDLE);
    assign rd_beat   = (rd_state == R_DATA) && axi.rvalid;

    axi_burst_counter #(.CNT_W(CNT_W), .IDX_W(IDX_W)) u_rd_cnt (
        .clk(clk), .reset(reset), .clear(rd_accept), .inc(rd_beat),
        .last_idx(rd_len[CNT_W-1:0]), .idx(rd_idx), .last(rd_last)
    );

    always_ff @(posedge clk) begin
        if (reset) rd_state <= R_IDLE;
        else       rd_state <= rd_next;
    end

    always_comb begin
        rd_next     = rd_state;
        rd_rdy      = 1'b0;
        rd_valid    = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        case (rd_state)
            R_IDLE: begin rd_rdy = 1'b1; if (rd_req) rd_next = R_ADDR; end
            R_ADDR: begin axi.arvalid = 1'b1; if (axi.arready) rd_next = R_DATA; end
            // an early rlast ends the burst; a missing one is cut off at arlen
            R_DATA: begin
                axi.rready = 1'b1;
                if (axi.rvalid && (rd_last || axi.rlast)) rd_next = R_DONE;
            end
            R_DONE: begin rd_valid = 1'b1; rd_next = R_IDLE; end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_q <= '0;
            rd_size_q <= '0;
            rd_unc_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_line   <= '0;
        end else if (rd_accept) begin
            rd_addr_q <= rd_addr;
            rd_size_q <= rd_size;
            rd_unc_q  <= rd_uncached;
            rd_err_q  <= 1'b0;
            rd_line   <= '0;
        end else if (rd_beat) begin
            rd_line[rd_idx] <= axi.rdata;
            if (axi.rresp != OKAY || axi.rid != AXI_ID || axi.rlast != rd_last)
                rd_err_q <= 1'b1;
        end
    end

    assign rd_err      = rd_valid && rd_err_q;
    assign rd_data     = rd_line;
    assign axi.arid    = AXI_ID;
    assign axi.araddr  = rd_addr_q;
    assign axi.arlen   = rd_len;
    assign axi.arsize  = rd_unc_q ? rd_size_q : FULL_SIZE;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = rd_unc_q ? 4'h0 : 4'hF;
    assign axi.arprot  = 3'b000;

    // ---------------- write engine ----------------
    line_wr_state_t                     wr_state, wr_next;
    logic [ADDR_W-1:0]                  wr_addr_q;
    logic [2:0]                         wr_size_q;
    logic [STRB_W-1:0]                  wr_strb_q;
    logic                               wr_unc_q, wr_err_q;
    logic [LINE_WORDS-1:0][DATA_W-1:0]  wr_line;
    logic [7:0]                         wr_len;
    logic [IDX_W-1:0]                   wr_idx;
    logic                               wr_last, wr_accept, wr_beat;

    assign wr_len    = wr_unc_q ? 8'd0 : LINE_LEN;
    assign wr_accept = wr_req && (wr_state == W_IDLE);
    assign wr_beat   = (wr_state == W_DATA) && axi.wready;

    axi_burst_counter #(.CNT_W(CNT_W), .IDX_W(IDX_W)) u_wr_cnt (
        .clk(clk), .reset(reset), .clear(wr_accept), .inc(wr_beat),
        .last_idx(wr_len[CNT_W-1:0]), .idx(wr_idx), .last(wr_last)
    );

    always_ff @(posedge clk) begin
        if (reset) wr_state <= W_IDLE;
        else       wr_state <= wr_next;
    end

    always_comb begin
        wr_next     = wr_state;
        wr_rdy      = 1'b0;
        wr_done     = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        case (wr_state)
            W_IDLE: begin wr_rdy = 1'b1; if (wr_req) wr_next = W_ADDR; end
            W_ADDR: begin axi.awvalid = 1'b1; if (axi.awready) wr_next = W_DATA; end
            W_DATA: begin axi.wvalid = 1'b1; if (axi.wready && wr_last) wr_next = W_RESP; end
            W_RESP: begin axi.bready = 1'b1; if (axi.bvalid) wr_next = W_DONE; end
            W_DONE: begin wr_done = 1'b1; wr_next = W_IDLE; end
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr_q <= '0;
            wr_size_q <= '0;
            wr_strb_q <= '0;
            wr_unc_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            wr_line   <= '0;
        end else if (wr_accept) begin
            wr_addr_q <= wr_addr;
            wr_size_q <= wr_size;
            wr_strb_q <= wr_strb;
            wr_unc_q  <= wr_uncached;
            wr_err_q  <= 1'b0;
            wr_line   <= wr_data;
        end else if (wr_state == W_RESP && axi.bvalid) begin
            wr_err_q  <= (axi.bresp != OKAY) || (axi.bid != AXI_ID);
        end
    end

    assign wr_err      = wr_done && wr_err_q;
    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = wr_addr_q;
    assign axi.awlen   = wr_len;
    assign axi.awsize  = wr_unc_q ? wr_size_q : FULL_SIZE;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = wr_unc_q ? 4'h0 : 4'hF;
    assign axi.awprot  = 3'b000;
    assign axi.wid     = AXI_ID;
    assign axi.wdata   = wr_line[wr_idx];
    assign axi.wstrb   = wr_unc_q ? wr_strb_q : {STRB_W{1'b1}};
    assign axi.wlast   = wr_last;
endmodule

// File: tb/tb_axi_line_master.sv
// Bench for axi_line_master: table of read bursts, hand-driven writes, concurrency
// and mid-burst reset, with channel monitors popping expectations from queues.
module tb_axi_line_master;
    import axi_line_master_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            rd_req, rd_uncached, rd_rdy, rd_valid, rd_err;
    logic [2:0]      rd_size;
    logic [AW-1:0]   rd_addr;
    logic [LW*DW-1:0] rd_data;
    logic            wr_req, wr_uncached, wr_rdy, wr_done, wr_err;
    logic [2:0]      wr_size;
    logic [DW/8-1:0] wr_strb;
    logic [AW-1:0]   wr_addr;
    logic [LW*DW-1:0] wr_data;

    always #5 clk = ~clk;

    axi_line_master_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    axi_line_master #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_uncached(rd_uncached), .rd_size(rd_size), .rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .rd_valid(rd_valid), .rd_err(rd_err), .rd_data(rd_data),
        .wr_req(wr_req), .wr_uncached(wr_uncached), .wr_size(wr_size), .wr_strb(wr_strb),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done),
        .wr_err(wr_err), .axi(axi)
    );

    typedef struct {
        logic         unc;
        logic [2:0]   size;
        logic [31:0]  addr;
        int           ar_dly;
        logic [127:0] beats;
        int           nbeats;
        int           rlast_at;
        int           bad_beat;
        logic [1:0]   bad_resp;
        logic [3:0]   bad_id;
        logic [7:0]   exp_len;
        logic [2:0]   exp_size;
        logic [3:0]   exp_cache;
        logic [127:0] exp_data;
        logic         exp_err;
    } rd_vec_t;

    typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [3:0] cache; } a_t;
    typedef struct { logic [127:0] data; logic err; } rd_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;

    a_t   ar_q[$], aw_q[$];
    rd_t  rd_q[$];
    w_t   w_q[$];
    logic wr_q[$];
    rd_vec_t rd_tbl[6];

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // channel monitors, sampled on the falling edge
    a_t ar_e, aw_e;
    rd_t rd_e;
    w_t w_e;
    logic wr_e;

    always @(negedge clk) if (!reset && axi.arvalid && axi.arready) begin
        if (ar_q.size() == 0) miss("ar unexpected");
        else begin
            ar_e = ar_q.pop_front();
            check("araddr", 128'(axi.araddr), 128'(ar_e.addr));
            check("arlen", 128'(axi.arlen), 128'(ar_e.len));
            check("arsize", 128'(axi.arsize), 128'(ar_e.size));
            check("arcache", 128'(axi.arcache), 128'(ar_e.cache));
            check("arburst", 128'(axi.arburst), 128'(2'b01));
        end
    end

    always @(negedge clk) if (!reset && axi.awvalid && axi.awready) begin
        if (aw_q.size() == 0) miss("aw unexpected");
        else begin
            aw_e = aw_q.pop_front();
            check("awaddr", 128'(axi.awaddr), 128'(aw_e.addr));
            check("awlen", 128'(axi.awlen), 128'(aw_e.len));
            check("awsize", 128'(axi.awsize), 128'(aw_e.size));
            check("awcache", 128'(axi.awcache), 128'(aw_e.cache));
        end
    end

    always @(negedge clk) if (!reset && axi.wvalid && axi.wready) begin
        if (w_q.size() == 0) miss("w beat unexpected");
        else begin
            w_e = w_q.pop_front();
            check("wdata", 128'(axi.wdata), 128'(w_e.data));
            check("wstrb", 128'(axi.wstrb), 128'(w_e.strb));
            check("wlast", 128'(axi.wlast), 128'(w_e.last));
        end
    end

    always @(negedge clk) if (!reset && rd_valid) begin
        if (rd_q.size() == 0) miss("rd_valid unexpected");
        else begin
            rd_e = rd_q.pop_front();
            check("rd_data", rd_data, rd_e.data);
            check("rd_err", 128'(rd_err), 128'(rd_e.err));
        end
    end

    always @(negedge clk) if (!reset && wr_done) begin
        if (wr_q.size() == 0) miss("wr_done unexpected");
        else begin
            wr_e = wr_q.pop_front();
            check("wr_err", 128'(wr_err), 128'(wr_e));
        end
    end

    task automatic do_read(input rd_vec_t v);
        int to;
        check("rd_rdy before req", 128'(rd_rdy), 128'(1'b1));
        ar_q.push_back('{v.addr, v.exp_len, v.exp_size, v.exp_cache});
        rd_q.push_back('{v.exp_data, v.exp_err});
        rd_req = 1'b1; rd_uncached = v.unc; rd_size = v.size; rd_addr = v.addr;
        tick();
        rd_req = 1'b0;
        for (int d = 0; d < v.ar_dly; d++) begin
            check("arvalid held", 128'(axi.arvalid), 128'(1'b1));
            tick();
        end
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        for (int b = 0; b < v.nbeats; b++) begin
            axi.rvalid = 1'b1;
            axi.rdata  = v.beats[b*32 +: 32];
            axi.rlast  = (b == v.rlast_at);
            axi.rresp  = (b == v.bad_beat) ? v.bad_resp : 2'b00;
            axi.rid    = (b == v.bad_beat) ? v.bad_id : 4'd0;
            tick();
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; axi.rid = 4'd0;
        to = 0;
        while (!rd_valid && to < 20) begin tick(); to++; end
        if (to >= 20) miss("rd_valid timeout");
        tick();
        check("rd_valid one cycle", 128'(rd_valid), 128'(1'b0));
    endtask

    task automatic exp_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        w_q.push_back('{d, s, l});
    endtask

    task automatic do_write(input logic unc, input logic [2:0] size, input logic [3:0] strb,
                            input logic [31:0] addr, input logic [127:0] line, input int nbeats,
                            input bit toggle, input logic [1:0] bresp, input logic [3:0] bid,
                            input logic [7:0] elen, input logic [2:0] esize,
                            input logic [3:0] ecache, input logic eerr);
        int sent, to;
        check("wr_rdy before req", 128'(wr_rdy), 128'(1'b1));
        aw_q.push_back('{addr, elen, esize, ecache});
        wr_q.push_back(eerr);
        wr_req = 1'b1; wr_uncached = unc; wr_size = size; wr_strb = strb;
        wr_addr = addr; wr_data = line;
        tick();
        wr_req = 1'b0;
        check("awvalid", 128'(axi.awvalid), 128'(1'b1));
        check("no wvalid before aw", 128'(axi.wvalid), 128'(1'b0));
        tick();
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        sent = 0; to = 0;
        while (sent < nbeats && to < 40) begin
            axi.wready = toggle ? (to % 2 == 1) : 1'b1;
            tick();
            if (axi.wready) sent++;
            to++;
        end
        axi.wready = 1'b0;
        if (to >= 40) miss("w beats timeout");
        check("bready", 128'(axi.bready), 128'(1'b1));
        axi.bvalid = 1'b1; axi.bresp = bresp; axi.bid = bid;
        tick();
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 4'd0;
        to = 0;
        while (!wr_done && to < 20) begin tick(); to++; end
        if (to >= 20) miss("wr_done timeout");
        tick();
        check("wr_done one cycle", 128'(wr_done), 128'(1'b0));
    endtask

    initial begin
        #500000;
        miss("watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rd_tbl[0] = '{1'b0, 3'd0, 32'h1FC0_0010, 2, 128'h0000000D_0000000C_0000000B_0000000A, 4, 3, -1,
                      2'b00, 4'h0, 8'd3, 3'd2, 4'hF, 128'h0000000D_0000000C_0000000B_0000000A, 1'b0};
        rd_tbl[1] = '{1'b1, 3'd1, 32'hBFAF_8002, 0, 128'h1234, 1, 0, -1,
                      2'b00, 4'h0, 8'd0, 3'd1, 4'h0, 128'h1234, 1'b0};
        // rlast on third beat and SLVERR on second
        rd_tbl[2] = '{1'b0, 3'd0, 32'h1000_0000, 1, 128'h00000044_00000033_00000022_00000011, 3, 2, 1,
                      2'b10, 4'h0, 8'd3, 3'd2, 4'hF, 128'h00000000_00000033_00000022_00000011, 1'b1};
        rd_tbl[3] = '{1'b0, 3'd0, 32'h1000_0040, 0, 128'h00000088_00000077_00000066_00000055, 4, -1, -1,
                      2'b00, 4'h0, 8'd3, 3'd2, 4'hF, 128'h00000088_00000077_00000066_00000055, 1'b1};
        rd_tbl[4] = '{1'b0, 3'd0, 32'h1000_0080, 0, 128'h0000CCCC_0000BBBB_0000AAAA_00009999, 4, 3, 0,
                      2'b00, 4'h5, 8'd3, 3'd2, 4'hF, 128'h0000CCCC_0000BBBB_0000AAAA_00009999, 1'b1};
        rd_tbl[5] = '{1'b1, 3'd0, 32'h8000_0003, 3, 128'h55, 1, 0, 0,
                      2'b11, 4'h0, 8'd0, 3'd0, 4'h0, 128'h55, 1'b1};

        reset = 1'b1;
        rd_req = 1'b0; rd_uncached = 1'b0; rd_size = 3'd0; rd_addr = '0;
        wr_req = 1'b0; wr_uncached = 1'b0; wr_size = 3'd0; wr_strb = '0; wr_addr = '0; wr_data = '0;
        axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rid = 4'd0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 4'd0;
        repeat (3) tick();
        reset = 1'b0;

        check("reset rd_rdy", 128'(rd_rdy), 128'(1'b1));
        check("reset wr_rdy", 128'(wr_rdy), 128'(1'b1));
        check("reset arvalid", 128'(axi.arvalid), 128'(1'b0));
        check("reset awvalid", 128'(axi.awvalid), 128'(1'b0));
        check("reset wvalid", 128'(axi.wvalid), 128'(1'b0));
        check("reset rready", 128'(axi.rready), 128'(1'b0));
        check("reset bready", 128'(axi.bready), 128'(1'b0));
        check("reset rd_valid", 128'(rd_valid), 128'(1'b0));
        check("reset wr_done", 128'(wr_done), 128'(1'b0));
        check("reset rd_data", rd_data, 128'h0);

        for (int i = 0; i < 6; i++) do_read(rd_tbl[i]);

        // cached writeback with a stuttering wready
        exp_w(32'd1, 4'hF, 1'b0); exp_w(32'd2, 4'hF, 1'b0);
        exp_w(32'd3, 4'hF, 1'b0); exp_w(32'd4, 4'hF, 1'b1);
        do_write(1'b0, 3'd0, 4'h0, 32'h0000_1000, 128'h00000004_00000003_00000002_00000001, 4,
                 1'b1, 2'b00, 4'd0, 8'd3, 3'd2, 4'hF, 1'b0);

        // uncached halfword store, slave answers SLVERR
        exp_w(32'h5678_0000, 4'hC, 1'b1);
        do_write(1'b1, 3'd1, 4'hC, 32'hBFAF_8002, 128'h5678_0000, 1,
                 1'b0, 2'b10, 4'd0, 8'd0, 3'd1, 4'h0, 1'b1);

        // wrong bid
        exp_w(32'h11, 4'hF, 1'b0); exp_w(32'h22, 4'hF, 1'b0);
        exp_w(32'h33, 4'hF, 1'b0); exp_w(32'h44, 4'hF, 1'b1);
        do_write(1'b0, 3'd0, 4'h0, 32'h0000_2000, 128'h00000044_00000033_00000022_00000011, 4,
                 1'b0, 2'b00, 4'h3, 8'd3, 3'd2, 4'hF, 1'b1);

        // read and write accepted on the same edge, slave serves both channels at once
        exp_w(32'd5, 4'hF, 1'b0); exp_w(32'd6, 4'hF, 1'b0);
        exp_w(32'd7, 4'hF, 1'b0); exp_w(32'd8, 4'hF, 1'b1);
        fork
            do_read(rd_tbl[0]);
            do_write(1'b0, 3'd0, 4'h0, 32'h3000_0000, 128'h00000008_00000007_00000006_00000005, 4,
                     1'b1, 2'b00, 4'd0, 8'd3, 3'd2, 4'hF, 1'b0);
        join

        // reset lands on the second data beat of a cached read
        check("rd_rdy before reset test", 128'(rd_rdy), 128'(1'b1));
        ar_q.push_back('{32'h2000_0000, 8'd3, 3'd2, 4'hF});
        rd_req = 1'b1; rd_uncached = 1'b0; rd_addr = 32'h2000_0000;
        tick();
        rd_req = 1'b0;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_0000; axi.rlast = 1'b0;
        tick();
        check("rready mid burst", 128'(axi.rready), 128'(1'b1));
        axi.rdata = 32'hDEAD_0001; reset = 1'b1;
        tick();
        check("post-reset rready", 128'(axi.rready), 128'(1'b0));
        check("post-reset arvalid", 128'(axi.arvalid), 128'(1'b0));
        check("post-reset rd_valid", 128'(rd_valid), 128'(1'b0));
        check("post-reset rd_rdy", 128'(rd_rdy), 128'(1'b1));
        check("post-reset rd_data", rd_data, 128'h0);
        reset = 1'b0; axi.rvalid = 1'b0;
        repeat (3) tick();
        check("no rd_valid after abort", 128'(rd_valid), 128'(1'b0));

        check("ar queue drained", 128'(ar_q.size()), 128'(0));
        check("aw queue drained", 128'(aw_q.size()), 128'(0));
        check("w queue drained", 128'(w_q.size()), 128'(0));
        check("rd queue drained", 128'(rd_q.size()), 128'(0));
        check("wr queue drained", 128'(wr_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
